key_event_ctrl: RTL and testbench

//  Turns debounced switch/key levels into discrete press events for the processor.

---
 rtl/key_event_ctrl_if.sv | 31 +++
 rtl/key_event_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_ctrl_if.sv
// Register-bus bundle between the CPU-side I/O decoder and key_event_ctrl.
// Purely combinational wiring. The bus has no handshake.
// A read strobe gets its data on the following cycle, and writes are accepted every cycle.
interface key_event_ctrl_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] rdata;
    logic        intr;

    // CPU / bus-decoder side
    modport master (
        output addr,
        output we,
        output wdata,
        output re,
        input  rdata,
        input  intr
    );

    // Key event controller side
    modport slave (
        input  addr,
        input  we,
        input  wdata,
        input  re,
        output rdata,
        output intr
    );
endinterface

// File: rtl/key_event_ctrl.sv
// Turns debounced key levels into press events and queues key indices for the CPU.
// Latency: press to pending takes 1 cycle, pending to FIFO takes 2 cycles, and a read returns RDATA 1 cycle after RE.
// Backpressure: a full FIFO stalls the scan and presses stay pending. Re-pressing a key that is still pending while the FIFO is full sets OVF.
module key_event_ctrl #(
    parameter int BITS  = 4,
    parameter int IDXW  = 2,
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITS-1:0]     din,
    key_event_ctrl_if.slave     bus
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_MASK   = 2'd3;

    localparam logic [PTRW:0] COUNT_FULL = (PTRW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state;
    logic [IDXW-1:0]   sel;

    logic [BITS-1:0]   prev;
    logic              armed;
    logic [BITS-1:0]   pending;
    logic              ovf;
    logic              ie;
    logic [BITS-1:0]   mask;

    logic [IDXW-1:0]   mem [DEPTH];
    logic [PTRW-1:0]   wp;
    logic [PTRW-1:0]   rp;
    logic [PTRW:0]     count;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [BITS-1:0]   rise;
    logic [BITS-1:0]   clr;
    logic [IDXW-1:0]   low_idx;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              rd_data_sel;
    logic              ovf_set;
    logic              ovf_clr;
    logic [PTRW:0]     count_next;
    logic [31:0]       rd_mux;

    // Rising edges of enabled keys. Armed blocks the first cycle after
    // reset, because prev is still zero then and a key held through reset
    // would otherwise look like a new press.
    assign rise = din & ~prev & mask & {BITS{armed}};

    assign full  = (count == COUNT_FULL);
    assign empty = (count == '0);

    // The FSM only enters PUSH when the FIFO has room, and a pop can only
    // lower the count, so a push never lands on a full FIFO.
    assign push = (state == PUSH);

    // A DATA read on an empty FIFO is not a pop, even if a push is landing
    // in the same cycle. The new entry becomes visible on the next read.
    assign rd_data_sel = bus.re && (bus.addr == ADDR_DATA);
    assign pop         = rd_data_sel && !empty;

    // Overflow: a press was lost because its key was already waiting and
    // there was no room to queue the earlier one.
    assign ovf_set = (|(rise & pending)) && full;
    assign ovf_clr = bus.we && (bus.addr == ADDR_STATUS) && bus.wdata[31];

    // Lowest-index pending key, chosen when the scan leaves IDLE.
    always_comb begin
        low_idx = '0;
        for (int i = BITS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IDXW'(i);
            end
        end
    end

    // One-hot clear for the key that is being written into the FIFO this cycle.
    always_comb begin
        clr = '0;
        if (push) begin
            clr[sel] = 1'b1;
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Read-data mux. The result is captured into RDATA only on a read strobe.
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_DATA: begin
                if (!empty) begin
                    rd_mux[31]         = 1'b1;
                    rd_mux[IDXW-1:0]   = mem[rp];
                end
            end
            ADDR_STATUS: begin
                rd_mux[31]         = ovf;
                rd_mux[8 +: BITS]  = pending;
                rd_mux[PTRW:0]     = count;
            end
            ADDR_CTRL: begin
                rd_mux[0] = ie;
            end
            default: begin
                rd_mux[BITS-1:0] = mask;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Edge history, arming, and the sticky pending mask.
    // A new press on the key being consumed this cycle stays pending, so it
    // is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            armed   <= 1'b0;
            pending <= '0;
        end else begin
            prev    <= din;
            armed   <= 1'b1;
            pending <= (pending & ~clr) | rise;
        end
    end

    // Sticky overflow flag. A new overflow wins over a simultaneous clear,
    // so the CPU never misses one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Scan FSM: pick the lowest pending key, then commit it to the FIFO on
    // the next cycle. This gives one event every two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((pending != '0) && !full) begin
                        sel   <= low_idx;
                        state <= PUSH;
                    end
                end
                PUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Event storage. It needs no reset because the pointers and count define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= sel;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            count <= count_next;
        end
    end

    // Control registers. Writes and reads in the same cycle are independent,
    // so a read returns the value from before the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie   <= 1'b0;
            mask <= '1;
        end else if (bus.we) begin
            case (bus.addr)
                ADDR_CTRL: ie   <= bus.wdata[0];
                ADDR_MASK: mask <= bus.wdata[BITS-1:0];
                default: ;
            endcase
        end
    end

    // Registered read data (it holds between reads) and the interrupt line.
    // The interrupt tracks the post-update occupancy, so it drops with the
    // pop that empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata <= '0;
            bus.intr  <= 1'b0;
        end else begin
            if (bus.re) begin
                bus.rdata <= rd_mux;
            end
            bus.intr <= ie & (count_next != '0);
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl.
// It uses a table of per-cycle vectors and then hand-written multi-cycle sequences.
// Expected read data goes into a scoreboard queue when RE is driven and is compared when RDATA updates.
module tb_key_event_ctrl;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_MASK = 2'd3;

    logic       clk;
    logic       rst;
    logic [3:0] din;

    key_event_ctrl_if bus ();

    key_event_ctrl #(
        .BITS  (4),
        .IDXW  (2),
        .DEPTH (4),
        .PTRW  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [3:0]  din;
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_intr;
    } vec_t;
    vec_t vt[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: RDATA update with no expected entry");
        end else begin
            e = sb_q.pop_front();
            check(e.name, bus.rdata, e.exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus.addr = a;
        bus.re   = 1'b1;
        sb_q.push_back('{exp, name});
        cyc();
        bus.re   = 1'b0;
        sb_check();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        bus.addr  = a;
        bus.wdata = data;
        bus.we    = 1'b1;
        cyc();
        bus.we    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic v(input logic [3:0] d, input logic w, input logic r, input logic [1:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic ei);
        vt.push_back('{d, w, r, a, wd, er, ei});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        din       = 4'b0001;
        bus.addr  = '0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        bus.wdata = '0;

        // Reset with key 0 held, then release and hold it. No event may appear.
        repeat (3) cyc();
        check("reset rdata", bus.rdata, 32'h0);
        check("reset intr", {31'b0, bus.intr}, 32'h0);
        rst = 1'b0;
        repeat (20) cyc();
        rd(A_STAT, 32'h0000_0000, "held key status");
        rd(A_MASK, 32'h0000_000F, "reset mask");
        rd(A_CTRL, 32'h0000_0000, "reset ctrl");
        rd(A_DATA, 32'h0000_0000, "reset data empty");
        check("held key intr", {31'b0, bus.intr}, 32'h0);

        // Per-cycle table: din, we, re, addr, wdata, exp_rdata, exp_intr
        v(4'b0000, 1, 0, A_CTRL, 32'h1, 32'h0, 0);          // IE=1
        v(4'b0100, 0, 0, A_DATA, 32'h0, 32'h0, 0);          // key 2 rise -> pending
        v(4'b0100, 0, 0, A_DATA, 32'h0, 32'h0, 0);          // IDLE->PUSH
        v(4'b0100, 0, 0, A_DATA, 32'h0, 32'h0, 1);          // pushed, count=1
        v(4'b0100, 0, 1, A_DATA, 32'h0, 32'h8000_0002, 0);  // pop idx 2
        v(4'b0100, 0, 1, A_STAT, 32'h0, 32'h0000_0000, 0);
        v(4'b0000, 0, 0, A_DATA, 32'h0, 32'h0, 0);
        v(4'b1011, 0, 0, A_DATA, 32'h0, 32'h0, 0);          // keys 0,1,3 rise together
        v(4'b1011, 0, 0, A_DATA, 32'h0, 32'h0, 0);
        v(4'b1011, 0, 0, A_DATA, 32'h0, 32'h0, 1);
        v(4'b1011, 0, 0, A_DATA, 32'h0, 32'h0, 1);
        v(4'b1011, 0, 0, A_DATA, 32'h0, 32'h0, 1);
        v(4'b1011, 0, 0, A_DATA, 32'h0, 32'h0, 1);
        v(4'b1011, 0, 0, A_DATA, 32'h0, 32'h0, 1);
        v(4'b1011, 0, 1, A_STAT, 32'h0, 32'h0000_0003, 1);  // count=3
        v(4'b1011, 0, 1, A_DATA, 32'h0, 32'h8000_0000, 1);
        v(4'b1011, 0, 1, A_DATA, 32'h0, 32'h8000_0001, 1);
        v(4'b1011, 0, 1, A_DATA, 32'h0, 32'h8000_0003, 0);
        v(4'b1011, 0, 1, A_DATA, 32'h0, 32'h0000_0000, 0);  // empty read
        v(4'b1011, 0, 1, A_STAT, 32'h0, 32'h0000_0000, 0);
        v(4'b1011, 1, 1, A_MASK, 32'hE, 32'h0000_000F, 0);  // WE+RE same cycle: old value
        v(4'b1011, 0, 1, A_MASK, 32'h0, 32'h0000_000E, 0);
        v(4'b0000, 0, 0, A_DATA, 32'h0, 32'h0, 0);
        v(4'b0001, 0, 0, A_DATA, 32'h0, 32'h0, 0);          // masked key 0
        v(4'b0001, 0, 0, A_DATA, 32'h0, 32'h0, 0);
        v(4'b0001, 0, 0, A_DATA, 32'h0, 32'h0, 0);
        v(4'b0001, 0, 1, A_STAT, 32'h0, 32'h0000_0000, 0);
        v(4'b0001, 1, 0, A_MASK, 32'hF, 32'h0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            din       = vt[i].din;
            bus.we    = vt[i].we;
            bus.re    = vt[i].re;
            bus.addr  = vt[i].addr;
            bus.wdata = vt[i].wdata;
            if (vt[i].re) sb_q.push_back('{vt[i].exp_rdata, $sformatf("vec%0d rdata", i)});
            cyc();
            check($sformatf("vec%0d intr", i), {31'b0, bus.intr}, {31'b0, vt[i].exp_intr});
            if (vt[i].re) sb_check();
        end
        bus.we = 1'b0;
        bus.re = 1'b0;

        // Fill the FIFO (0,1,3,0), then key 2 waits pending and a re-press sets OVF.
        din = 4'b0000; cyc();
        din = 4'b1011; repeat (8) cyc();
        din = 4'b0000; cyc();
        din = 4'b0001; repeat (4) cyc();
        rd(A_STAT, 32'h0000_0004, "fill count");
        din = 4'b0000; cyc();
        din = 4'b0100; repeat (3) cyc();
        rd(A_STAT, 32'h0000_0404, "full pending");
        din = 4'b0000; cyc();
        din = 4'b0100; cyc();
        rd(A_STAT, 32'h8000_0404, "ovf set");
        check("full intr", {31'b0, bus.intr}, 32'h1);
        rd(A_DATA, 32'h8000_0000, "pop while full");
        cyc(); cyc();
        rd(A_STAT, 32'h8000_0004, "pending pushed after pop");
        wr(A_STAT, 32'h8000_0000);
        rd(A_STAT, 32'h0000_0004, "ovf cleared");
        rd(A_DATA, 32'h8000_0001, "order 1");
        rd(A_DATA, 32'h8000_0003, "order 3");
        rd(A_DATA, 32'h8000_0000, "order 0");
        rd(A_DATA, 32'h8000_0002, "order 2");
        check("drained intr", {31'b0, bus.intr}, 32'h0);
        rd(A_DATA, 32'h0000_0000, "drained empty");

        // A new press on the key being pushed in the same cycle stays pending.
        din = 4'b0000; cyc();
        din = 4'b1000; cyc();
        din = 4'b0000; cyc();
        din = 4'b1000; cyc();
        rd(A_STAT, 32'h0000_0801, "rise during clr");
        cyc();
        rd(A_STAT, 32'h0000_0002, "second push");
        rd(A_DATA, 32'h8000_0003, "repeat key a");
        rd(A_DATA, 32'h8000_0003, "repeat key b");

        // A pop on an empty FIFO in the same cycle as a push sees empty.
        din = 4'b0000; cyc();
        din = 4'b0010; cyc();
        cyc();
        rd(A_DATA, 32'h0000_0000, "pop empty during push");
        rd(A_DATA, 32'h8000_0001, "push landed");

        // A pop during PUSH at count=2 leaves count at 2 and keeps the order.
        din = 4'b0000; cyc();
        din = 4'b0011; repeat (5) cyc();
        din = 4'b0000; cyc();
        din = 4'b0100; cyc();
        cyc();
        rd(A_DATA, 32'h8000_0000, "pop during push");
        rd(A_STAT, 32'h0000_0002, "count unchanged");
        rd(A_DATA, 32'h8000_0001, "order after push a");
        rd(A_DATA, 32'h8000_0002, "order after push b");

        // Reset mid-operation with count=3 and the FSM in PUSH.
        din = 4'b0000; cyc();
        din = 4'b1111; cyc();
        wr(A_MASK, 32'h3);
        repeat (5) cyc();
        rd(A_STAT, 32'h0000_0803, "pre-reset status");
        check("pre-reset intr", {31'b0, bus.intr}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async reset rdata", bus.rdata, 32'h0);
        check("async reset intr", {31'b0, bus.intr}, 32'h0);
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc();
        rd(A_STAT, 32'h0000_0000, "post-reset status");
        rd(A_MASK, 32'h0000_000F, "post-reset mask");
        rd(A_CTRL, 32'h0000_0000, "post-reset ctrl");
        check("post-reset intr", {31'b0, bus.intr}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
